// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic DEPTH-entry in-order pipeline register carrying an
// opaque WIDTH-bit payload between two pipeline stages.
// Ports:
//   CLK, RST (async, active-high)
//   in_valid/in_data/in_ready: upstream side; in_ready is registered
//   out_valid/out_data/out_ready: downstream side; out_data is 0 when empty
//   flush: squash held entries and any same-cycle enqueue
//   count: current occupancy
// Optional macro PIPE_STAGE_PERF_EN adds the saturating counters
// stall_cycles, bubble_cycles and flush_count.
module pipe_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      bubble_cycles,
  output logic [15:0]      flush_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;

  logic             w_enq;
  logic             w_deq;
  logic             w_out_valid;
  logic [CNT_W-1:0] w_count_nxt;

  // Explicit wrap so non-power-of-2 depths never rely on truncation.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_out_valid = (r_count != '0);
  assign w_enq       = in_valid & r_in_ready;
  assign w_deq       = w_out_valid & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_enq & ~w_deq)
      w_count_nxt = r_count + 1'b1;
    else if (~w_enq & w_deq)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      // Registered from next occupancy: no out_ready -> in_ready path.
      r_in_ready <= (w_count_nxt < FULL_CNT);
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq) r_tail <= f_inc(r_tail);
        if (w_deq) r_head <= f_inc(r_head);
      end
    end
  end

  // Storage is deliberately not reset; occupancy alone marks validity.
  always_ff @(posedge CLK) begin
    if (w_enq & ~flush)
      r_mem[r_tail] <= in_data;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_mem[r_head] : '0;
  assign count     = r_count;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall;
  logic [31:0] r_bubble;
  logic [15:0] r_flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall  <= '0;
      r_bubble <= '0;
      r_flush  <= '0;
    end else begin
      if (in_valid & ~r_in_ready & ~&r_stall)
        r_stall <= r_stall + 1'b1;
      if (~w_out_valid & ~&r_bubble)
        r_bubble <= r_bubble + 1'b1;
      if (flush & ~&r_flush)
        r_flush <= r_flush + 1'b1;
    end
  end

  assign stall_cycles  = r_stall;
  assign bubble_cycles = r_bubble;
  assign flush_count   = r_flush;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: randomized and directed checks of pipe_stage_buf
// against a queue-based model, with DEPTH=2 and DEPTH=3 instances.
module tb_pipe_stage_buf;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        rdy2, vld2;
  logic [63:0] dat2;
  logic [1:0]  cnt2;
  logic        rdy3, vld3;
  logic [63:0] dat3;
  logic [1:0]  cnt3;

  int n_cmp;
  int n_bad;

  logic [63:0] q2[$];
  logic [63:0] q3[$];
  logic [63:0] out3_log[$];
  int m_stall, m_bubble, m_flush;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] st2, bu2, st3, bu3;
  logic [15:0] fl2, fl3;
`endif

  pipe_stage_buf #(.WIDTH(64), .DEPTH(2)) u_dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .out_valid(vld2), .out_data(dat2), .out_ready(out_ready),
    .flush(flush), .count(cnt2)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(st2), .bubble_cycles(bu2), .flush_count(fl2)
`endif
  );

  pipe_stage_buf #(.WIDTH(64), .DEPTH(3)) u_dut3 (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy3),
    .out_valid(vld3), .out_data(dat3), .out_ready(out_ready),
    .flush(flush), .count(cnt3)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(st3), .bubble_cycles(bu3), .flush_count(fl3)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle, advance the model by the handshake rules, land #1
  // after the edge.
  task automatic cycle(input logic v, input logic [63:0] d,
                       input logic r, input logic f);
    bit e2, e3, d2, d3;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    e2 = v && (q2.size() < 2);
    e3 = v && (q3.size() < 3);
    d2 = (q2.size() != 0) && r;
    d3 = (q3.size() != 0) && r;
    if (v && !(q2.size() < 2)) m_stall++;
    if (q2.size() == 0) m_bubble++;
    if (f) m_flush++;
    if (vld3 && r && !f) out3_log.push_back(dat3);
    @(posedge CLK);
    if (f) begin
      q2.delete();
      q3.delete();
    end else begin
      if (d2) void'(q2.pop_front());
      if (e2) q2.push_back(d);
      if (d3) void'(q3.pop_front());
      if (e3) q3.push_back(d);
    end
    #1;
  endtask

  task automatic model_clear();
    q2.delete();
    q3.delete();
    out3_log.delete();
    m_stall  = 0;
    m_bubble = 0;
    m_flush  = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    #2;
    model_clear();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    #2;
    model_clear();
    n_cmp++;
    if ({vld2, rdy2, cnt2, dat2} !== {1'b0, 1'b1, 2'd0, 64'd0}) begin
      n_bad++;
      $display("FAIL rst_async got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=0",
               vld2, rdy2, cnt2, dat2);
    end
    RST = 1'b0;
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({vld2, rdy2, cnt2, dat2} !== {1'b0, 1'b1, 2'd0, 64'd0}) begin
      n_bad++;
      $display("FAIL rst_idle got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=0",
               vld2, rdy2, cnt2, dat2);
    end
    n_cmp++;
    if ({vld3, rdy3, cnt3} !== {1'b0, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL rst_idle3 got v=%b r=%b c=%0d want v=0 r=1 c=0",
               vld3, rdy3, cnt3);
    end
  endtask

  task automatic test_stream();
    logic [63:0] vals [3];
    vals[0] = 64'h1111;
    vals[1] = 64'h2222;
    vals[2] = 64'h3333;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vals[i], 1'b1, 1'b0);
      n_cmp++;
      if ({vld2, rdy2, cnt2, dat2} !== {1'b1, 1'b1, 2'd1, vals[i]}) begin
        n_bad++;
        $display("FAIL stream_%0d got v=%b r=%b c=%0d d=%h want v=1 r=1 c=1 d=%h",
                 i, vld2, rdy2, cnt2, dat2, vals[i]);
      end
    end
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    n_cmp++;
    if ({vld2, cnt2, dat2} !== {1'b0, 2'd0, 64'd0}) begin
      n_bad++;
      $display("FAIL stream_drain got v=%b c=%0d d=%h want v=0 c=0 d=0",
               vld2, cnt2, dat2);
    end
  endtask

  task automatic test_backpressure();
    // {in_valid, data, out_ready} per cycle; then expected c/ready/data.
    logic        sv [6];
    logic [63:0] sd [6];
    logic        sr [6];
    logic [1:0]  ec [6];
    logic        er [6];
    logic [63:0] ed [6];
    sv = '{1, 1, 1, 1, 1, 0};
    sd = '{64'hA, 64'hB, 64'hC, 64'hC, 64'hC, 64'h0};
    sr = '{0, 0, 0, 1, 1, 1};
    ec = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    er = '{1, 0, 0, 1, 1, 1};
    ed = '{64'hA, 64'hA, 64'hA, 64'hB, 64'hC, 64'h0};
    for (int i = 0; i < 6; i++) begin
      cycle(sv[i], sd[i], sr[i], 1'b0);
      n_cmp++;
      if ({cnt2, rdy2, dat2} !== {ec[i], er[i], ed[i]}) begin
        n_bad++;
        $display("FAIL bp_%0d got c=%0d r=%b d=%h want c=%0d r=%b d=%h",
                 i, cnt2, rdy2, dat2, ec[i], er[i], ed[i]);
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 64'h51, 1'b0, 1'b0);
    cycle(1'b1, 64'h52, 1'b0, 1'b0);
    n_cmp++;
    if (cnt2 !== 2'd2) begin
      n_bad++;
      $display("FAIL flush_fill got c=%0d want c=2", cnt2);
    end
    cycle(1'b1, 64'hDEAD, 1'b1, 1'b1);
    n_cmp++;
    if ({vld2, rdy2, cnt2, dat2} !== {1'b0, 1'b1, 2'd0, 64'd0}) begin
      n_bad++;
      $display("FAIL flush_now got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=0",
               vld2, rdy2, cnt2, dat2);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
      n_cmp++;
      if ((vld2 !== 1'b0) || (dat2 === 64'hDEAD)) begin
        n_bad++;
        $display("FAIL flush_after_%0d got v=%b d=%h want v=0 d=0",
                 i, vld2, dat2);
      end
    end
  endtask

  task automatic test_wrap_d3();
    logic [63:0] sent[$];
    int pushed;
    int budget;
    bit v;
    bit r;
    logic [63:0] d;
    pushed = 0;
    budget = 0;
    out3_log.delete();
    d = {$urandom, $urandom};
    while ((out3_log.size() < 10) && (budget < 80)) begin
      v = (pushed < 10) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (v && (q3.size() < 3)) begin
        sent.push_back(d);
        pushed++;
      end
      cycle(v, d, r, 1'b0);
      if (v && (sent.size() == pushed) && (sent[pushed-1] == d))
        d = {$urandom, $urandom};
      budget++;
      n_cmp++;
      if (cnt3 > 2'd3) begin
        n_bad++;
        $display("FAIL wrap_cnt got c=%0d want <=3", cnt3);
      end
    end
    n_cmp++;
    if (out3_log.size() != 10) begin
      n_bad++;
      $display("FAIL wrap_timeout got %0d pops want 10", out3_log.size());
    end
    for (int i = 0; i < 10 && i < out3_log.size(); i++) begin
      n_cmp++;
      if (out3_log[i] !== sent[i]) begin
        n_bad++;
        $display("FAIL wrap_seq_%0d got %h want %h", i, out3_log[i], sent[i]);
      end
    end
  endtask

  task automatic test_random();
    bit pend;
    logic [63:0] pd;
    bit v;
    bit r;
    bit f;
    logic [63:0] e2;
    logic [63:0] e3;
    pend = 0;
    pd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 2) != 0);
        pd = {$urandom, $urandom};
      end else begin
        v = 1'b1;
      end
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 19) == 0);
      pend = v && !(q2.size() < 2) && !f;
      cycle(v, pd, r, f);
      e2 = (q2.size() != 0) ? q2[0] : 64'd0;
      e3 = (q3.size() != 0) ? q3[0] : 64'd0;
      n_cmp++;
      if ({vld2, rdy2, cnt2, dat2} !==
          {q2.size() != 0, q2.size() < 2, 2'(q2.size()), e2}) begin
        n_bad++;
        $display("FAIL rand2_%0d got v=%b r=%b c=%0d d=%h want c=%0d d=%h",
                 i, vld2, rdy2, cnt2, dat2, q2.size(), e2);
      end
      n_cmp++;
      if ({vld3, rdy3, cnt3, dat3} !==
          {q3.size() != 0, q3.size() < 3, 2'(q3.size()), e3}) begin
        n_bad++;
        $display("FAIL rand3_%0d got v=%b r=%b c=%0d d=%h want c=%0d d=%h",
                 i, vld3, rdy3, cnt3, dat3, q3.size(), e3);
      end
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    do_reset();
    @(posedge CLK);
    #1;
    model_clear();
    m_bubble = 1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    cycle(1'b1, 64'h1, 1'b0, 1'b0);
    cycle(1'b1, 64'h2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h3, 1'b0, 1'b0);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    n_cmp++;
    if (st2 !== 32'(m_stall) || m_stall != 5) begin
      n_bad++;
      $display("FAIL perf_stall got %0d want %0d (5)", st2, m_stall);
    end
    n_cmp++;
    if (bu2 !== 32'(m_bubble)) begin
      n_bad++;
      $display("FAIL perf_bubble got %0d want %0d", bu2, m_bubble);
    end
    n_cmp++;
    if (fl2 !== 16'd2) begin
      n_bad++;
      $display("FAIL perf_flush got %0d want 2", fl2);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({st2, bu2, fl2} !== 80'd0) begin
      n_bad++;
      $display("FAIL perf_rst got %0d %0d %0d want 0 0 0", st2, bu2, fl2);
    end
    #1;
    model_clear();
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap_d3();
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
